// File: rtl/axi_bridge_pkg.sv
// Shared types and constants for the AXI-Lite to AXI-Stream bridge.
package axi_bridge_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_EMIT,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_REQ,
    R_WAIT,
    R_RESP
  } rd_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Unsigned window test; an address below base wraps to a huge offset and also fails addr >= base.
  function automatic logic addr_in_window(input logic [31:0] addr, input logic [31:0] base,
                                          input logic [31:0] span);
    logic [31:0] offset;
    offset = addr - base;
    return (addr >= base) && (offset < span);
  endfunction

endpackage

// File: rtl/axil_to_axis_if.sv
// Bus bundles used by the bridge: a 32-bit AXI-Lite port and a 32/32 AXI-Stream port.
interface axi_lite_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

interface axi_stream_if;
  logic [31:0] data;
  logic [31:0] dest;
  logic        valid;
  logic        ready;

  modport master (
    output data, dest, valid,
    input  ready
  );

  modport slave (
    input  data, dest, valid,
    output ready
  );
endinterface

// File: rtl/bridge_timeout.sv
// Read-response wait counter; expired fires in the cycle whose count step reaches LIMIT.
module bridge_timeout #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned Width = $clog2(LIMIT + 1);
  localparam logic [Width-1:0] LastCount = Width'(LIMIT - 1);
  localparam logic [Width-1:0] MaxCount  = Width'(LIMIT);

  logic [Width-1:0] count_q;

  // Count enabled cycles from zero, saturating at LIMIT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != MaxCount)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = enable && (count_q >= LastCount);

endmodule

// File: rtl/axil_to_axis.sv
// AXI-Lite slave that turns writes into stream beats and reads into request/response beats.
module axil_to_axis
  import axi_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS   = 32'h43c0_0000,
  parameter logic [31:0] ADDR_SPAN      = 32'h0000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic          clock,
  input logic          reset,
  axi_lite_if.slave    axi_in,
  axi_stream_if.master axis_write,
  axi_stream_if.master axis_read_request,
  axi_stream_if.slave  axis_read_response
);

  wr_state_e   wr_state_q;
  logic        aw_got_q, w_got_q, aw_ok_q;
  logic [31:0] wr_data_q, wr_dest_q;
  logic        wr_valid_q;
  logic        b_valid_q;
  logic [1:0]  b_resp_q;

  rd_state_e   rd_state_q;
  logic [31:0] req_dest_q;
  logic        req_valid_q;
  logic [31:0] r_data_q;
  logic [1:0]  r_resp_q;
  logic        r_valid_q;

  logic        aw_ready, w_ready, ar_ready, rsp_ready;
  logic        aw_hs, w_hs, ar_hs;
  logic [31:0] aw_offset, ar_offset;
  logic        aw_in_win, ar_in_win;
  logic        timeout_expired;

  // Readies come straight from state so they are 1 in the first cycle after reset release.
  assign aw_ready  = reset && (wr_state_q == W_IDLE) && !aw_got_q;
  assign w_ready   = reset && (wr_state_q == W_IDLE) && !w_got_q;
  assign ar_ready  = reset && (rd_state_q == R_IDLE);
  assign rsp_ready = reset && (rd_state_q == R_WAIT);

  assign aw_hs = axi_in.awvalid && aw_ready;
  assign w_hs  = axi_in.wvalid && w_ready;
  assign ar_hs = axi_in.arvalid && ar_ready;

  assign aw_offset = axi_in.awaddr - BASE_ADDRESS;
  assign ar_offset = axi_in.araddr - BASE_ADDRESS;
  assign aw_in_win = addr_in_window(axi_in.awaddr, BASE_ADDRESS, ADDR_SPAN);
  assign ar_in_win = addr_in_window(axi_in.araddr, BASE_ADDRESS, ADDR_SPAN);

  assign axi_in.awready = aw_ready;
  assign axi_in.wready  = w_ready;
  assign axi_in.bvalid  = b_valid_q;
  assign axi_in.bresp   = b_resp_q;
  assign axi_in.arready = ar_ready;
  assign axi_in.rvalid  = r_valid_q;
  assign axi_in.rdata   = r_data_q;
  assign axi_in.rresp   = r_resp_q;

  assign axis_write.valid = wr_valid_q;
  assign axis_write.data  = wr_data_q;
  assign axis_write.dest  = wr_dest_q;

  assign axis_read_request.valid = req_valid_q;
  assign axis_read_request.data  = '0;
  assign axis_read_request.dest  = req_dest_q;

  assign axis_read_response.ready = rsp_ready;

  bridge_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .enable  (rd_state_q == R_WAIT),
    .clear   (rd_state_q != R_WAIT),
    .expired (timeout_expired)
  );

  // Write FSM: collect AW and W in any order, emit one beat, then answer on B.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_state_q <= W_IDLE;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      aw_ok_q    <= 1'b0;
      wr_data_q  <= '0;
      wr_dest_q  <= '0;
      wr_valid_q <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= OKAY;
    end else begin
      unique case (wr_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            aw_got_q  <= 1'b1;
            aw_ok_q   <= aw_in_win;
            wr_dest_q <= aw_offset;
          end
          if (w_hs) begin
            w_got_q   <= 1'b1;
            wr_data_q <= axi_in.wdata;
          end
          if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            if (aw_hs ? aw_in_win : aw_ok_q) begin
              wr_valid_q <= 1'b1;
              wr_state_q <= W_EMIT;
            end else begin
              b_valid_q  <= 1'b1;
              b_resp_q   <= DECERR;
              wr_state_q <= W_RESP;
            end
          end
        end
        W_EMIT: begin
          if (axis_write.ready) begin
            wr_valid_q <= 1'b0;
            b_valid_q  <= 1'b1;
            b_resp_q   <= OKAY;
            wr_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (axi_in.bready) begin
            b_valid_q  <= 1'b0;
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  // Read FSM: issue a request beat, wait for a response or the timeout, then answer on R.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_state_q  <= R_IDLE;
      req_dest_q  <= '0;
      req_valid_q <= 1'b0;
      r_data_q    <= '0;
      r_resp_q    <= OKAY;
      r_valid_q   <= 1'b0;
    end else begin
      unique case (rd_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            if (ar_in_win) begin
              req_valid_q <= 1'b1;
              req_dest_q  <= ar_offset;
              rd_state_q  <= R_REQ;
            end else begin
              r_valid_q  <= 1'b1;
              r_data_q   <= '0;
              r_resp_q   <= DECERR;
              rd_state_q <= R_RESP;
            end
          end
        end
        R_REQ: begin
          if (axis_read_request.ready) begin
            req_valid_q <= 1'b0;
            rd_state_q  <= R_WAIT;
          end
        end
        R_WAIT: begin
          // A response in the timeout cycle takes priority.
          if (axis_read_response.valid) begin
            r_valid_q  <= 1'b1;
            r_data_q   <= axis_read_response.data;
            r_resp_q   <= OKAY;
            rd_state_q <= R_RESP;
          end else if (timeout_expired) begin
            r_valid_q  <= 1'b1;
            r_data_q   <= '0;
            r_resp_q   <= SLVERR;
            rd_state_q <= R_RESP;
          end
        end
        R_RESP: begin
          if (axi_in.rready) begin
            r_valid_q  <= 1'b0;
            rd_state_q <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

endmodule
